// File: rtl/if_id_reg.sv
// Fetch->decode pipeline register with stall/flush handling, a sticky HALT
// state that freezes fetch, and a saturating bubble-cycle counter.
module if_id_reg #(
  parameter int INSTR_W = 16,
  parameter int PC_W = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc2_in,
  input  logic               fetch_valid,
  input  logic               stall,
  input  logic               flush,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc2_out,
  output logic               valid_out,
  output logic               halt_req,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef enum logic {
    RUN       = 1'b0,
    HALT_HELD = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [PC_W-1:0]      pc2_q, pc2_d;
  logic                 valid_q, valid_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 is_halt_op;
  assign is_halt_op = (instr_in[INSTR_W-1 -: 5] == 5'b00000);

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc2_d   = pc2_q;
    valid_d = valid_q;
    unique case (state_q)
      RUN: begin
        if (flush) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (stall) begin
          // hold everything
        end else if (fetch_valid) begin
          instr_d = instr_in;
          pc2_d   = pc2_in;
          valid_d = 1'b1;
          if (is_halt_op) state_d = HALT_HELD;
        end else begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
      HALT_HELD: begin
        // A taken branch means the HALT was on the wrong path; cancel it.
        if (flush) begin
          state_d = RUN;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase

    cnt_d = cnt_q;
    if (!valid_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      instr_q <= NOP_INSTR;
      pc2_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc2_q   <= pc2_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_out  = instr_q;
  assign pc2_out    = pc2_q;
  assign valid_out  = valid_q;
  assign halt_req   = (state_q == HALT_HELD);
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Bench for if_id_reg: directed scenarios plus random traffic, checked by a
// queue-based scoreboard fed from a behavioural model.
module tb_if_id_reg;

  localparam int W = 50;
  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr_in = '0;
  logic [15:0] pc2_in = '0;
  logic        fetch_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] instr_out;
  logic [15:0] pc2_out;
  logic        valid_out;
  logic        halt_req;
  logic [15:0] bubble_cnt;

  if_id_reg dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc2_in(pc2_in),
    .fetch_valid(fetch_valid), .stall(stall), .flush(flush),
    .instr_out(instr_out), .pc2_out(pc2_out), .valid_out(valid_out),
    .halt_req(halt_req), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: what the decode stage should see, plus a plain
  // unbounded count of bubble cycles that is clipped only when reported.
  logic [15:0] m_instr = NOP;
  logic [15:0] m_pc2 = '0;
  logic        m_valid = 1'b0;
  logic        m_halted = 1'b0;
  int          m_bubbles = 0;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic step(input logic r, input logic fv, input logic [15:0] ins,
                      input logic [15:0] pc, input logic st, input logic fl);
    logic [15:0] rep_cnt;
    @(negedge clk);
    rst = r; fetch_valid = fv; instr_in = ins; pc2_in = pc; stall = st; flush = fl;
    if (r) begin
      m_instr = NOP; m_pc2 = '0; m_valid = 1'b0; m_halted = 1'b0; m_bubbles = 0;
    end else begin
      if (fl) begin
        m_instr = NOP; m_valid = 1'b0; m_halted = 1'b0;
      end else if (!(st || m_halted)) begin
        if (fv) begin
          m_instr = ins; m_pc2 = pc; m_valid = 1'b1;
          m_halted = (ins[15:11] == 5'd0);
        end else begin
          m_instr = NOP; m_valid = 1'b0;
        end
      end
      if (!m_valid) m_bubbles++;
    end
    rep_cnt = (m_bubbles > 65535) ? 16'hFFFF : m_bubbles[15:0];
    exp_q.push_back({m_instr, m_pc2, m_valid, m_halted, rep_cnt});
  endtask

  // Monitor: every rising edge the register presents a new state; compare
  // it against the oldest outstanding expectation.
  logic [W-1:0] exp_v, act_v;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {instr_out, pc2_out, valid_out, halt_req, bubble_cnt};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL out_state t=%0t actual instr=%h pc2=%h valid=%b halt=%b cnt=%h required instr=%h pc2=%h valid=%b halt=%b cnt=%h",
                 $time, act_v[49:34], act_v[33:18], act_v[17], act_v[16], act_v[15:0],
                 exp_v[49:34], exp_v[33:18], exp_v[17], exp_v[16], exp_v[15:0]);
      end
    end
  end

  initial begin
    logic [15:0] ri;
    // 1: reset for two cycles
    step(1, 0, 16'h0000, 16'h0000, 0, 0);
    step(1, 0, 16'h0000, 16'h0000, 0, 0);
    // 2: load ADDI
    step(0, 1, 16'h4105, 16'h0002, 0, 0);
    // 3: stall three cycles while input changes
    step(0, 1, 16'h1234, 16'h0004, 1, 0);
    step(0, 1, 16'h0000, 16'h0006, 1, 0);
    step(0, 0, 16'h5678, 16'h0008, 1, 0);
    // 4: stall and flush together
    step(0, 1, 16'h4105, 16'h000A, 1, 1);
    // 5: HALT, then later fetches ignored, then flush cancels it
    step(0, 1, 16'h0000, 16'h000C, 0, 0);
    step(0, 1, 16'h4105, 16'h000E, 0, 0);
    step(0, 1, 16'h4105, 16'h0010, 1, 0);
    step(0, 0, 16'h4105, 16'h0012, 0, 0);
    step(0, 1, 16'h4105, 16'h0014, 0, 1);
    // HALT offered during flush is not captured
    step(0, 1, 16'h0000, 16'h0016, 0, 1);
    step(0, 1, 16'h07FF, 16'h0018, 0, 0);
    // Reset from inside HALT_HELD
    step(0, 1, 16'h0001, 16'h001A, 0, 0);
    step(1, 1, 16'h4105, 16'h001C, 1, 0);
    step(0, 1, 16'h4105, 16'h001E, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      ri = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ri[15:11] = 5'd0;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), ri,
           16'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
    end

    // 6: long bubble run saturates the counter, then reset clears it
    step(1, 0, 16'h0000, 16'h0000, 0, 0);
    for (int i = 0; i < 70000; i++) step(0, 0, 16'h4105, 16'h0002, 0, 0);
    step(0, 0, 16'h4105, 16'h0002, 1, 0);
    step(1, 0, 16'h0000, 16'h0000, 0, 0);
    step(0, 1, 16'h4105, 16'h0002, 0, 0);

    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual %0d pending expectations, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
